// File: rtl/video_stream_tx_pkg.sv
// Shared canny video package: default raster timing, pattern encodings,
// FSM state type and the pixel pattern generator used by video_stream_tx.
package video_stream_tx_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b1;

  // Counters need 11 bits: 1024 active pixels plus blanking exceeds 10 bits.
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    PatExternal = 2'd0,
    PatRamp     = 2'd1,
    PatChecker  = 2'd2,
    PatReserved = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Reserved encoding behaves as external.
  function automatic logic pat_is_ext(input logic [1:0] sel);
    return !((sel == PatRamp) || (sel == PatChecker));
  endfunction

  function automatic logic [7:0] pixel_gen(input logic [1:0]         sel,
                                           input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y,
                                           input logic [7:0]         ext);
    logic [7:0] pix;
    case (pattern_e'(sel))
      PatRamp:    pix = x[7:0];
      PatChecker: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default:    pix = ext;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster timing counters with de/hs/vs decode (active-high, unregistered).
// Ports: i_clk, i_rst_n (async, active-low), i_en (advance counters);
//        o_h_cnt/o_v_cnt current position, o_de/o_hs/o_vs decode,
//        o_last high at the final count of a frame.
module vid_timing_cnt
  import video_stream_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_h_last, w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;
  assign o_de    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign o_hs    = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign o_vs    = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign o_last  = w_h_last && w_v_last;

endmodule

// File: rtl/video_stream_tx.sv
// Video stream transmitter: run/drain FSM, pattern select, two-stage output
// pipeline (stage 1 = pixel request + delayed syncs, stage 2 = video stream).
// Ports: i_clk, i_rst_n (async, active-low), i_en run request,
//        i_pattern_sel source select; o_px_req/o_px_x/o_px_y external read,
//        i_px_data read data one clk after o_px_req; o_vid_data/o_vid_hs/
//        o_vid_vs/o_vid_de output stream; o_frame_start, o_busy status.
module video_stream_tx
  import video_stream_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [1:0]         i_pattern_sel,
  output logic               o_px_req,
  output logic [COORD_W-1:0] o_px_x,
  output logic [COORD_W-1:0] o_px_y,
  input  logic [7:0]         i_px_data,
  output logic [7:0]         o_vid_data,
  output logic               o_vid_hs,
  output logic               o_vid_vs,
  output logic               o_vid_de,
  output logic               o_frame_start,
  output logic               o_busy
);

  state_e           r_state, w_state_next;
  logic             w_running;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_de, w_hs, w_vs, w_last, w_origin;
  logic [1:0]       r_pat, w_pat;

  // Stage 1 registers
  logic               r_px_req, r_de1, r_hs1, r_vs1, r_fs1;
  logic [COORD_W-1:0] r_px_x, r_px_y;
  logic [1:0]         r_pat1;

  // Stage 2 registers
  logic [7:0] r_vid_data;
  logic       r_vid_hs, r_vid_vs, r_vid_de, r_frame_start;

  vid_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_running),
    .o_h_cnt (w_h_cnt),
    .o_v_cnt (w_v_cnt),
    .o_de    (w_de),
    .o_hs    (w_hs),
    .o_vs    (w_vs),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // A frame only ends at its last count; en at that point decides whether
  // the next frame follows back-to-back.
  always_comb begin
    w_state_next = r_state;
    w_running    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_en) w_state_next = StRun;
      end
      StRun: begin
        w_running = 1'b1;
        if (!i_en) w_state_next = w_last ? StIdle : StDrain;
      end
      StDrain: begin
        w_running = 1'b1;
        if (i_en)        w_state_next = StRun;
        else if (w_last) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Pattern is captured at the frame origin; the origin pixel itself
  // already uses the freshly sampled value.
  assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);
  assign w_pat    = w_origin ? i_pattern_sel : r_pat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat    <= '0;
      r_px_req <= 1'b0;
      r_px_x   <= '0;
      r_px_y   <= '0;
      r_de1    <= 1'b0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_fs1    <= 1'b0;
      r_pat1   <= '0;
    end else begin
      if (w_running && w_origin) r_pat <= i_pattern_sel;
      r_px_req <= w_running && w_de && pat_is_ext(w_pat);
      r_px_x   <= w_h_cnt[COORD_W-1:0];
      r_px_y   <= w_v_cnt[COORD_W-1:0];
      r_de1    <= w_running && w_de;
      r_hs1    <= w_running && w_hs;
      r_vs1    <= w_running && w_vs;
      r_fs1    <= w_running && w_origin;
      r_pat1   <= w_pat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vid_data    <= 8'h00;
      r_vid_de      <= 1'b0;
      r_vid_hs      <= ~SYNC_POL;
      r_vid_vs      <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_vid_data    <= r_de1 ? pixel_gen(r_pat1, r_px_x, r_px_y, i_px_data) : 8'h00;
      r_vid_de      <= r_de1;
      r_vid_hs      <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      r_vid_vs      <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= r_fs1;
    end
  end

  assign o_px_req      = r_px_req;
  assign o_px_x        = r_px_x;
  assign o_px_y        = r_px_y;
  assign o_vid_data    = r_vid_data;
  assign o_vid_de      = r_vid_de;
  assign o_vid_hs      = r_vid_hs;
  assign o_vid_vs      = r_vid_vs;
  assign o_frame_start = r_frame_start;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_video_stream_tx.sv
module tb_video_stream_tx;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] pat = 2'd0;
  logic [7:0] px_data = 8'h00;
  logic       px_req, vid_hs, vid_vs, vid_de, fs, busy;
  logic [9:0] px_x, px_y;
  logic [7:0] vid_data;

  logic       en16 = 1'b0;
  logic [1:0] pat16 = 2'd0;
  logic [7:0] px_data16 = 8'h00;
  logic       px_req16, vid_hs16, vid_vs16, vid_de16, fs16, busy16;
  logic [9:0] px_x16, px_y16;
  logic [7:0] vid_data16;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] key = 8'h00;

  video_stream_tx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pattern_sel(pat),
    .o_px_req(px_req), .o_px_x(px_x), .o_px_y(px_y), .i_px_data(px_data),
    .o_vid_data(vid_data), .o_vid_hs(vid_hs), .o_vid_vs(vid_vs), .o_vid_de(vid_de),
    .o_frame_start(fs), .o_busy(busy)
  );

  video_stream_tx #(
    .H_ACTIVE(16), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en16), .i_pattern_sel(pat16),
    .o_px_req(px_req16), .o_px_x(px_x16), .o_px_y(px_y16), .i_px_data(px_data16),
    .o_vid_data(vid_data16), .o_vid_hs(vid_hs16), .o_vid_vs(vid_vs16),
    .o_vid_de(vid_de16), .o_frame_start(fs16), .o_busy(busy16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // External pixel memory: answers a read one clk after the request, garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (px_req) px_data = 8'((32'(px_x) + 32'(px_y) * 16) ^ 32'(key));
    else        px_data = 8'($urandom);
  end

  // ---------------- Reference model (frame-position based) ----------------
  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       de, hs, vs, fs;
    logic [1:0] pat;
  } s1_t;

  bit         sb_on = 1'b0;
  bit         m_run = 1'b0;
  int         m_n = 0;
  logic [1:0] m_pat = 2'd0;
  s1_t        m_s1 = '0;
  logic [7:0] e_data = 8'h00;
  logic       e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;

  function automatic logic [7:0] exp_pix(input logic [1:0] p, input int x, input int y);
    if (p == 2'd1) return 8'(x % 256);
    if (p == 2'd2) return ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
    return 8'((x + 16 * y) ^ int'(key));
  endfunction

  always @(posedge clk) begin
    if (sb_on) begin
      int h, v;
      e_de   = m_s1.de;
      e_hs   = m_s1.hs;
      e_vs   = m_s1.vs;
      e_fs   = m_s1.fs;
      e_data = m_s1.de ? exp_pix(m_s1.pat, int'(m_s1.x), int'(m_s1.y)) : 8'h00;
      h = m_n % HT;
      v = m_n / HT;
      if (m_run && m_n == 0) m_pat = (pat == 2'd3) ? 2'd0 : pat;
      m_s1 = '0;
      if (m_run) begin
        m_s1.x   = 10'(h);
        m_s1.y   = 10'(v);
        m_s1.de  = (h < HA) && (v < VA);
        m_s1.hs  = (h >= HA + HF) && (h < HA + HF + HS);
        m_s1.vs  = (v >= VA + VF) && (v < VA + VF + VS);
        m_s1.fs  = (m_n == 0);
        m_s1.pat = m_pat;
        m_s1.req = m_s1.de && (m_pat == 2'd0);
      end
      // A frame runs to its end; en at its final clock decides whether another follows.
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_n = 0; end
      end else if (m_n == FT - 1) begin
        m_n = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_n++;
      end
    end
  end

  always @(posedge clk) begin
    if (sb_on) begin
      #2;
      check("scoreboard",
            {px_req, px_x, px_y, vid_data, vid_de, vid_hs, vid_vs, fs, busy},
            {m_s1.req, m_s1.x, m_s1.y, e_data, e_de, e_hs, e_vs, e_fs, m_run});
    end
  end

  // ---------------- Directed table ----------------
  typedef struct {
    logic       en;
    logic [1:0] pat;
    int         cycles;
    int         de, hs, vs, fs, busy, dsum;
  } vec_t;

  vec_t tbl[4];

  task automatic do_reset();
    en = 1'b0; en16 = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hs_log[300];
  logic vs_log[300];
  logic fs_log[300];
  logic [7:0] cap16[200];

  initial begin
    int c_de, c_hs, c_vs, c_fs, c_busy, c_sum, t_fs1, t_fs2, t_hs, t_vs, n, last_busy;
    int late_req, c_req;
    logic [7:0] q[$];

    tbl[0] = '{en: 1'b0, pat: 2'd1, cycles: 30,  de: 0,  hs: 0,  vs: 0,  fs: 0, busy: 0,   dsum: 0};
    tbl[1] = '{en: 1'b1, pat: 2'd1, cycles: 196, de: 64, hs: 28, vs: 28, fs: 2, busy: 196, dsum: 224};
    tbl[2] = '{en: 1'b1, pat: 2'd2, cycles: 100, de: 32, hs: 14, vs: 14, fs: 1, busy: 100, dsum: 0};
    tbl[3] = '{en: 1'b1, pat: 2'd0, cycles: 50,  de: 30, hs: 6,  vs: 0,  fs: 1, busy: 50,  dsum: 771};

    // Asynchronous reset state
    #2 rst_n = 1'b0;
    #1 check("reset_state", {px_req, px_x, px_y, vid_data, vid_de, vid_hs, vid_vs, fs, busy}, 64'h0);
    do_reset();
    check("idle_hs_level", {vid_hs, vid_vs}, 2'b00);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      key = 8'h00;
      en  = tbl[i].en;
      pat = tbl[i].pat;
      c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0; c_busy = 0; c_sum = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        tick();
        c_de += int'(vid_de); c_hs += int'(vid_hs); c_vs += int'(vid_vs);
        c_fs += int'(fs); c_busy += int'(busy);
        if (vid_de) c_sum += int'(vid_data);
      end
      check($sformatf("row%0d_de", i), 64'(c_de), 64'(tbl[i].de));
      check($sformatf("row%0d_hs", i), 64'(c_hs), 64'(tbl[i].hs));
      check($sformatf("row%0d_vs", i), 64'(c_vs), 64'(tbl[i].vs));
      check($sformatf("row%0d_fs", i), 64'(c_fs), 64'(tbl[i].fs));
      check($sformatf("row%0d_busy", i), 64'(c_busy), 64'(tbl[i].busy));
      check($sformatf("row%0d_dsum", i), 64'(c_sum), 64'(tbl[i].dsum));
    end

    // Sync placement and frame period
    do_reset();
    en = 1'b1; pat = 2'd1;
    for (int c = 0; c < 300; c++) begin
      tick();
      hs_log[c] = vid_hs; vs_log[c] = vid_vs; fs_log[c] = fs;
    end
    t_fs1 = -1; t_fs2 = -1; t_hs = -1; t_vs = -1;
    for (int c = 0; c < 300; c++) begin
      if (fs_log[c] && t_fs1 < 0) t_fs1 = c;
      else if (fs_log[c] && t_fs2 < 0) t_fs2 = c;
      if (hs_log[c] && t_hs < 0) t_hs = c;
      if (vs_log[c] && t_vs < 0) t_vs = c;
    end
    check("frame_period", 64'(t_fs2 - t_fs1), 64'(FT));
    check("hs_offset", 64'(t_hs - t_fs1), 64'(HA + HF));
    check("vs_offset", 64'(t_vs - t_fs1), 64'((VA + VF) * HT));
    n = 0;
    for (int c = 0; c < HT; c++) if (t_fs1 >= 0) n += int'(hs_log[t_fs1 + c]);
    check("hs_width", 64'(n), 64'(HS));
    n = 0;
    for (int c = 0; c < FT; c++) if (t_fs1 >= 0) n += int'(vs_log[t_fs1 + c]);
    check("vs_width", 64'(n), 64'(VS * HT));

    // External pixel path
    do_reset();
    key = 8'h00; en = 1'b1; pat = 2'd0;
    q = {};
    for (int c = 0; c < 100; c++) begin
      tick();
      if (vid_de) q.push_back(vid_data);
    end
    check("ext_count", 64'(q.size()), 64'(HA * VA));
    for (int i = 0; i < q.size() && i < HA * VA; i++)
      check($sformatf("ext_px%0d", i), 64'(q[i]), 64'((i % HA) + 16 * (i / HA)));

    // en dropped at (3,1): frame completes, then idle
    do_reset();
    en = 1'b1; pat = 2'd0;
    c_de = 0; c_busy = 0; last_busy = -1; late_req = 0; c_req = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      c_de += int'(vid_de); c_busy += int'(busy); c_req += int'(px_req);
      if (busy) last_busy = c;
      if (c > FT && px_req) late_req++;
      if (c == 1 + HT + 3) en = 1'b0;
    end
    check("drain_de", 64'(c_de), 64'(HA * VA));
    check("drain_busy", 64'(c_busy), 64'(FT));
    check("drain_last_busy", 64'(last_busy), 64'(FT));
    check("drain_req", 64'(c_req), 64'(HA * VA));
    check("drain_late_req", 64'(late_req), 64'(0));

    // Reset mid-frame at (5,2)
    do_reset();
    en = 1'b1; pat = 2'd1;
    repeat (1 + 2 * HT + 5) tick();
    check("pre_reset_busy", {busy, vid_de}, 2'b11);
    rst_n = 1'b0;
    #1 check("mid_reset", {px_req, px_x, px_y, vid_data, vid_de, vid_hs, vid_vs, fs, busy}, 64'h0);
    repeat (2) tick();
    check("reset_hold_busy", {busy, px_x}, 11'h0);
    rst_n = 1'b1;
    t_fs1 = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (fs && t_fs1 < 0) t_fs1 = c;
    end
    check("restart_fs_delay", 64'(t_fs1), 64'(3));

    // Pattern switch mid-frame on the wide instance
    do_reset();
    en16 = 1'b1; pat16 = 2'd1;
    n = 0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (vid_de16) begin
        if (n < 200) cap16[n] = vid_data16;
        n++;
      end
      if (c == 40) pat16 = 2'd2;
    end
    check("p16_count", 64'(n), 64'(192));
    check("p16_f1_x8", 64'(cap16[8]), 64'(8'd8));
    check("p16_f1_last", 64'(cap16[63]), 64'(8'd15));
    check("p16_f2_x0", 64'(cap16[64]), 64'(8'h00));
    check("p16_f2_x8", 64'(cap16[72]), 64'(8'hFF));
    check("p16_f2_x15", 64'(cap16[79]), 64'(8'hFF));
    check("p16_f2_y1x0", 64'(cap16[80]), 64'(8'h00));
    en16 = 1'b0;

    // Randomized run against the model
    do_reset();
    repeat (3) tick();
    key   = 8'($urandom);
    m_run = 1'b0; m_n = 0; m_pat = 2'd0; m_s1 = '0;
    e_data = 8'h00; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
    en = 1'b1; pat = 2'($urandom_range(0, 3));
    sb_on = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) pat = 2'($urandom_range(0, 3));
    end
    sb_on = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
